// File: rtl/switch_debounce.sv
// Per-channel switch conditioner: two-flop synchroniser, stable-count debounce,
// and registered one-cycle rise/fall pulses aligned with the debounced level change.
module switch_debounce #(
    parameter int   NUM_SWITCHES   = 4,
    parameter int   DEBOUNCE_LIMIT = 250000,
    parameter logic INIT_LEVEL     = 1'b0
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic [NUM_SWITCHES-1:0] i_Switch,
    output logic [NUM_SWITCHES-1:0] o_Switch,
    output logic [NUM_SWITCHES-1:0] o_Rise,
    output logic [NUM_SWITCHES-1:0] o_Fall
);

    localparam int              CW        = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0]   COUNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

    logic [NUM_SWITCHES-1:0] sync1_q;
    logic [NUM_SWITCHES-1:0] sync2_q;
    logic [NUM_SWITCHES-1:0] level_q;
    logic [NUM_SWITCHES-1:0] level_d;
    logic [NUM_SWITCHES-1:0] rise_q;
    logic [NUM_SWITCHES-1:0] rise_d;
    logic [NUM_SWITCHES-1:0] fall_q;
    logic [NUM_SWITCHES-1:0] fall_d;
    logic [CW-1:0]           count_q [NUM_SWITCHES];
    logic [CW-1:0]           count_d [NUM_SWITCHES];

    // The count only runs while the synchronised pin disagrees with the
    // debounced level; any agreement (a bounce back) restarts it from zero.
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int n = 0; n < NUM_SWITCHES; n++) begin
            count_d[n] = '0;
            if (sync2_q[n] != level_q[n]) begin
                if (count_q[n] == COUNT_MAX) begin
                    level_d[n] = sync2_q[n];
                    rise_d[n]  = sync2_q[n];
                    fall_d[n]  = ~sync2_q[n];
                end else begin
                    count_d[n] = count_q[n] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync1_q <= {NUM_SWITCHES{INIT_LEVEL}};
            sync2_q <= {NUM_SWITCHES{INIT_LEVEL}};
            level_q <= {NUM_SWITCHES{INIT_LEVEL}};
            rise_q  <= '0;
            fall_q  <= '0;
            for (int n = 0; n < NUM_SWITCHES; n++) begin
                count_q[n] <= '0;
            end
        end else begin
            sync1_q <= i_Switch;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int n = 0; n < NUM_SWITCHES; n++) begin
                count_q[n] <= count_d[n];
            end
        end
    end

    assign o_Switch = level_q;
    assign o_Rise   = rise_q;
    assign o_Fall   = fall_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce with DEBOUNCE_LIMIT=4: segment table of held inputs
// with expected outputs per cycle, plus hand-written latency and reset sequences.
module tb_switch_debounce;

    localparam int NSW = 4;

    logic           clk;
    logic           rst;
    logic [NSW-1:0] sw_in;
    logic [NSW-1:0] sw_out;
    logic [NSW-1:0] rise;
    logic [NSW-1:0] fall;

    int checks;
    int errors;

    switch_debounce #(
        .NUM_SWITCHES   (NSW),
        .DEBOUNCE_LIMIT (4),
        .INIT_LEVEL     (1'b0)
    ) dut (
        .i_Clk    (clk),
        .i_Reset  (rst),
        .i_Switch (sw_in),
        .o_Switch (sw_out),
        .o_Rise   (rise),
        .o_Fall   (fall)
    );

    // Clock and initial input state
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A segment holds (rst, pins) for n edges; expected outputs hold after each of them
    typedef struct {
        logic           rst;
        logic [NSW-1:0] sw;
        int             n;
        logic [NSW-1:0] exp_sw;
        logic [NSW-1:0] exp_rise;
        logic [NSW-1:0] exp_fall;
    } seg_t;

    seg_t segs[$];

    function automatic seg_t mk(logic r, logic [NSW-1:0] s, int n,
                                logic [NSW-1:0] es, logic [NSW-1:0] er, logic [NSW-1:0] ef);
        seg_t t;
        t.rst = r; t.sw = s; t.n = n;
        t.exp_sw = es; t.exp_rise = er; t.exp_fall = ef;
        return t;
    endfunction

    task automatic check(string name, int idx, logic [NSW-1:0] got, logic [NSW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at step %0d: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic drive(logic r, logic [NSW-1:0] s);
        @(negedge clk);
        rst   = r;
        sw_in = s;
    endtask

    initial begin
        int step;
        int lat;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        sw_in  = 4'hF;

        // 1. reset with all pins high, then release: flip 5 edges after first sample
        segs.push_back(mk(1, 4'hF, 3, 4'h0, 4'h0, 4'h0));
        segs.push_back(mk(0, 4'hF, 5, 4'h0, 4'h0, 4'h0));
        segs.push_back(mk(0, 4'hF, 1, 4'hF, 4'hF, 4'h0));
        segs.push_back(mk(0, 4'hF, 1, 4'hF, 4'h0, 4'h0));
        // all channels released together
        segs.push_back(mk(0, 4'h0, 5, 4'hF, 4'h0, 4'h0));
        segs.push_back(mk(0, 4'h0, 1, 4'h0, 4'h0, 4'hF));
        segs.push_back(mk(0, 4'h0, 2, 4'h0, 4'h0, 4'h0));
        // 2. ch0 press then release
        segs.push_back(mk(0, 4'h1, 5, 4'h0, 4'h0, 4'h0));
        segs.push_back(mk(0, 4'h1, 1, 4'h1, 4'h1, 4'h0));
        segs.push_back(mk(0, 4'h1, 2, 4'h1, 4'h0, 4'h0));
        segs.push_back(mk(0, 4'h0, 5, 4'h1, 4'h0, 4'h0));
        segs.push_back(mk(0, 4'h0, 1, 4'h0, 4'h0, 4'h1));
        segs.push_back(mk(0, 4'h0, 2, 4'h0, 4'h0, 4'h0));
        // 3. ch1 bounce 1,0,1,0 then steady 1
        segs.push_back(mk(0, 4'h2, 1, 4'h0, 4'h0, 4'h0));
        segs.push_back(mk(0, 4'h0, 1, 4'h0, 4'h0, 4'h0));
        segs.push_back(mk(0, 4'h2, 1, 4'h0, 4'h0, 4'h0));
        segs.push_back(mk(0, 4'h0, 1, 4'h0, 4'h0, 4'h0));
        segs.push_back(mk(0, 4'h2, 5, 4'h0, 4'h0, 4'h0));
        segs.push_back(mk(0, 4'h2, 1, 4'h2, 4'h2, 4'h0));
        segs.push_back(mk(0, 4'h2, 2, 4'h2, 4'h0, 4'h0));
        // 4. ch2 glitch of 3 cycles never reaches the output
        segs.push_back(mk(0, 4'h6, 3, 4'h2, 4'h0, 4'h0));
        segs.push_back(mk(0, 4'h2, 6, 4'h2, 4'h0, 4'h0));
        // 5. ch3 mid-debounce reset; ch1 level is also cleared silently
        segs.push_back(mk(0, 4'hA, 4, 4'h2, 4'h0, 4'h0));
        segs.push_back(mk(1, 4'hA, 1, 4'h0, 4'h0, 4'h0));
        segs.push_back(mk(0, 4'hA, 5, 4'h0, 4'h0, 4'h0));
        segs.push_back(mk(0, 4'hA, 1, 4'hA, 4'hA, 4'h0));
        segs.push_back(mk(0, 4'hA, 2, 4'hA, 4'h0, 4'h0));
        // 6. ch0 rises and ch3 falls on the same edge, ch1 stays high
        segs.push_back(mk(0, 4'h3, 5, 4'hA, 4'h0, 4'h0));
        segs.push_back(mk(0, 4'h3, 1, 4'h3, 4'h1, 4'h8));
        segs.push_back(mk(0, 4'h3, 2, 4'h3, 4'h0, 4'h0));

        step = 0;
        foreach (segs[i]) begin
            for (int c = 0; c < segs[i].n; c++) begin
                drive(segs[i].rst, segs[i].sw);
                @(posedge clk);
                #1;
                check("level", step, sw_out, segs[i].exp_sw);
                check("rise",  step, rise,   segs[i].exp_rise);
                check("fall",  step, fall,   segs[i].exp_fall);
                step++;
            end
        end

        // Latency: ch2 pressed, rise pulse expected on the 6th edge (k=5), bounded wait
        drive(1'b0, 4'h7);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (rise != 4'h0) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL latency: got %0d edges expected 5", lat);
        end
        check("lat_level", step, sw_out, 4'h7);
        check("lat_rise",  step, rise,   4'h4);
        @(posedge clk);
        #1;
        check("lat_pulse_end", step, rise, 4'h0);

        // Reset with pins high clears everything without any pulse
        drive(1'b1, 4'h7);
        @(posedge clk);
        #1;
        check("rst_level", step, sw_out, 4'h0);
        check("rst_rise",  step, rise,   4'h0);
        check("rst_fall",  step, fall,   4'h0);
        drive(1'b0, 4'h0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check("post_rst_quiet", k, sw_out | rise | fall, 4'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
